// File: rtl/guess_hint_engine_if.sv
// ============================================================================
//  Module      : guess_hint_engine_if
//  Description : Handshake and BOARD_RAM write bus between the game FSM
//                (master) and the guess/hint engine (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface guess_hint_engine_if #(
  parameter int MAX_PINS    = 20,
  parameter int PIN_POS_W   = 5,
  parameter int PIN_COLOR_W = 5,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8
);
  // Job request side
  logic                            START;
  logic                            ABORT;
  logic [PIN_POS_W-1:0]            PINS_COUNT;
  logic [7:0]                      GUESS_INDEX;
  logic [MAX_PINS*PIN_COLOR_W-1:0] GUESS;
  logic [MAX_PINS*PIN_COLOR_W-1:0] SECRET;
  // Job status / result side
  logic                            BUSY;
  logic                            DONE;
  logic [PIN_POS_W-1:0]            GREEN;
  logic [PIN_POS_W-1:0]            YELLOW;
  // BOARD_RAM write port
  logic                            RAM_WEN;
  logic [ADDR_W-1:0]               RAM_WADDR;
  logic [DATA_W-1:0]               RAM_DATA;

  modport master (
    output START, ABORT, PINS_COUNT, GUESS_INDEX, GUESS, SECRET,
    input  BUSY, DONE, GREEN, YELLOW, RAM_WEN, RAM_WADDR, RAM_DATA
  );

  modport slave (
    input  START, ABORT, PINS_COUNT, GUESS_INDEX, GUESS, SECRET,
    output BUSY, DONE, GREEN, YELLOW, RAM_WEN, RAM_WADDR, RAM_DATA
  );
endinterface

`default_nettype wire

// File: rtl/guess_hint_engine.sv
// ============================================================================
//  Module      : guess_hint_engine
//  Description : Writes one committed Mastermind guess row to BOARD_RAM,
//                scores it against the secret (green = exact, yellow =
//                colour elsewhere) and writes the yellow/green pair to the
//                hint region. START/DONE handshake, ABORT cancels a job.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_hint_engine #(
  parameter int MAX_PINS     = 20,
  parameter int PIN_POS_W    = 5,
  parameter int PIN_COLOR_W  = 5,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int HINTS_OFFSET = 2048
) (
  input  logic               CLK,
  input  logic               RST,
  guess_hint_engine_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PIN   = 3'd1;
  localparam logic [2:0] S_CROSS = 3'd2;
  localparam logic [2:0] S_WR_Y  = 3'd3;
  localparam logic [2:0] S_WR_G  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [PIN_POS_W-1:0] c_max_pins = PIN_POS_W'(MAX_PINS);
  localparam logic [PIN_POS_W-1:0] c_last_pin = PIN_POS_W'(MAX_PINS - 1);

  // Control state
  logic [2:0]              r_state;
  logic [PIN_POS_W-1:0]    r_idx;      // pin index in PIN
  logic [PIN_POS_W-1:0]    r_g;        // guess index in CROSS
  logic [PIN_POS_W-1:0]    r_s;        // secret index in CROSS
  logic [PIN_POS_W-1:0]    r_p;        // clamped active pin count
  logic [7:0]              r_gidx;
  logic [PIN_POS_W-1:0]    r_green_acc;
  logic [PIN_POS_W-1:0]    r_yellow_acc;
  logic [MAX_PINS-1:0]     r_ga;       // guess pins already consumed
  logic [MAX_PINS-1:0]     r_sa;       // secret pins already consumed
  logic [PIN_COLOR_W-1:0]  r_guess  [MAX_PINS];
  logic [PIN_COLOR_W-1:0]  r_secret [MAX_PINS];

  // Registered outputs
  logic                    r_busy;
  logic                    r_done;
  logic [PIN_POS_W-1:0]    r_green;
  logic [PIN_POS_W-1:0]    r_yellow;
  logic                    r_wen;
  logic [ADDR_W-1:0]       r_waddr;
  logic [DATA_W-1:0]       r_data;

  logic                    w_accept;
  logic [PIN_POS_W-1:0]    w_p_clamped;
  logic [PIN_COLOR_W-1:0]  w_pin_g;
  logic [PIN_COLOR_W-1:0]  w_pin_s;
  logic [PIN_COLOR_W-1:0]  w_cross_g;
  logic [PIN_COLOR_W-1:0]  w_cross_s;
  logic                    w_pin_hit;
  logic                    w_cross_hit;
  logic                    w_last_pin;
  logic                    w_last_s;
  logic                    w_last_g;
  logic [ADDR_W-1:0]       w_row_base;
  logic [ADDR_W-1:0]       w_hint_base;

  // ABORT has priority over START even while idle
  assign w_accept    = (r_state == S_IDLE) && bus.START && !bus.ABORT;
  assign w_p_clamped = (bus.PINS_COUNT > c_max_pins) ? c_max_pins : bus.PINS_COUNT;

  assign w_pin_g     = r_guess[r_idx];
  assign w_pin_s     = r_secret[r_idx];
  assign w_cross_g   = r_guess[r_g];
  assign w_cross_s   = r_secret[r_s];

  assign w_pin_hit   = (w_pin_g == w_pin_s) && !r_ga[r_idx] && !r_sa[r_idx];
  assign w_cross_hit = (r_g != r_s) && (w_cross_g == w_cross_s) &&
                       !r_ga[r_g] && !r_sa[r_s];

  assign w_last_pin  = (r_idx == c_last_pin);
  assign w_last_s    = (r_s == r_p - 1'b1);
  assign w_last_g    = (r_g == r_p - 1'b1);

  // Row base and hint pair base; both wrap to the RAM address width
  assign w_row_base  = ADDR_W'(32'(r_gidx) * MAX_PINS);
  assign w_hint_base = ADDR_W'(HINTS_OFFSET) + ADDR_W'({r_gidx, 1'b0});

  // Capture the guess/secret colours when a job is accepted
  always_ff @(posedge CLK) begin
    if (!RST && w_accept) begin
      for (int i = 0; i < MAX_PINS; i++) begin
        r_guess[i]  <= bus.GUESS[i*PIN_COLOR_W +: PIN_COLOR_W];
        r_secret[i] <= bus.SECRET[i*PIN_COLOR_W +: PIN_COLOR_W];
      end
    end
  end

  // Job sequencer: pin upload with green scan, cross scan, hint writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_g          <= '0;
      r_s          <= '0;
      r_p          <= '0;
      r_gidx       <= '0;
      r_green_acc  <= '0;
      r_yellow_acc <= '0;
      r_ga         <= '0;
      r_sa         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_green      <= '0;
      r_yellow     <= '0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
    end else if (bus.ABORT) begin
      // Cancel: hint results from the previous job are kept
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wen   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wen  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_p          <= w_p_clamped;
            r_gidx       <= bus.GUESS_INDEX;
            r_idx        <= '0;
            r_green_acc  <= '0;
            r_yellow_acc <= '0;
            r_ga         <= '0;
            r_sa         <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_PIN;
          end
        end

        S_PIN: begin
          r_wen   <= 1'b1;
          r_waddr <= w_row_base + ADDR_W'(r_idx);
          r_data  <= DATA_W'(w_pin_g);
          // Inactive slots are retired so the cross scan never sees them
          if (r_idx >= r_p) begin
            r_ga[r_idx] <= 1'b1;
            r_sa[r_idx] <= 1'b1;
          end else if (w_pin_hit) begin
            r_ga[r_idx] <= 1'b1;
            r_sa[r_idx] <= 1'b1;
            r_green_acc <= r_green_acc + 1'b1;
          end
          if (w_last_pin) begin
            r_idx   <= '0;
            r_g     <= '0;
            r_s     <= '0;
            r_state <= (r_p == '0) ? S_WR_Y : S_CROSS;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_CROSS: begin
          if (w_cross_hit) begin
            r_ga[r_g]    <= 1'b1;
            r_sa[r_s]    <= 1'b1;
            r_yellow_acc <= r_yellow_acc + 1'b1;
          end
          if (w_last_s) begin
            r_s <= '0;
            if (w_last_g) begin
              r_state <= S_WR_Y;
            end else begin
              r_g <= r_g + 1'b1;
            end
          end else begin
            r_s <= r_s + 1'b1;
          end
        end

        S_WR_Y: begin
          r_wen   <= 1'b1;
          r_waddr <= w_hint_base;
          r_data  <= DATA_W'(r_yellow_acc);
          r_state <= S_WR_G;
        end

        S_WR_G: begin
          r_wen   <= 1'b1;
          r_waddr <= w_hint_base + ADDR_W'(1);
          r_data  <= DATA_W'(r_green_acc);
          r_state <= S_FIN;
        end

        S_FIN: begin
          r_done   <= 1'b1;
          r_green  <= r_green_acc;
          r_yellow <= r_yellow_acc;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.GREEN     = r_green;
  assign bus.YELLOW    = r_yellow;
  assign bus.RAM_WEN   = r_wen;
  assign bus.RAM_WADDR = r_waddr;
  assign bus.RAM_DATA  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_guess_hint_engine.sv
// ============================================================================
//  Module      : tb_guess_hint_engine
//  Description : Directed self-checking bench for guess_hint_engine with a
//                behavioural BOARD_RAM on the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_guess_hint_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  guess_hint_engine_if bus ();

  guess_hint_engine dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural BOARD_RAM plus write counters
  logic [7:0] ram [4096];
  int         wr_count;
  int         hint_wr;
  logic       clr_ram = 1'b0;

  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'hEE;
      wr_count <= 0;
      hint_wr  <= 0;
    end else if (bus.RAM_WEN) begin
      ram[bus.RAM_WADDR] <= bus.RAM_DATA;
      wr_count <= wr_count + 1;
      if (bus.RAM_WADDR >= 12'd2048) hint_wr <= hint_wr + 1;
    end
  end

  // Pins 0..3 from arguments; pins 4..19 equal their index when fill is set
  function automatic logic [99:0] pack4(input int a0, input int a1,
                                        input int a2, input int a3,
                                        input bit fill);
    logic [99:0] v;
    v = '0;
    v[0  +: 5] = 5'(a0);
    v[5  +: 5] = 5'(a1);
    v[10 +: 5] = 5'(a2);
    v[15 +: 5] = 5'(a3);
    if (fill) for (int i = 4; i < 20; i++) v[i*5 +: 5] = 5'(i);
    return v;
  endfunction

  task automatic clear_ram();
    @(negedge clk); clr_ram = 1'b1;
    @(negedge clk); clr_ram = 1'b0;
  endtask

  task automatic kick(input logic [99:0] g, input logic [99:0] s,
                      input logic [4:0] pc, input logic [7:0] gi);
    @(negedge clk);
    bus.GUESS = g; bus.SECRET = s; bus.PINS_COUNT = pc; bus.GUESS_INDEX = gi;
    bus.START = 1'b1;
    @(posedge clk); #1 bus.START = 1'b0;
  endtask

  // lat = number of cycles after the START edge at which DONE is seen, -1 on timeout
  task automatic run_job(input logic [99:0] g, input logic [99:0] s,
                         input logic [4:0] pc, input logic [7:0] gi,
                         output int lat);
    kick(g, s, pc, gi);
    lat = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (bus.DONE) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.BUSY, bus.DONE, bus.RAM_WEN} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {bus.BUSY, bus.DONE, bus.RAM_WEN});
    end
    checks++;
    if ({bus.GREEN, bus.YELLOW, bus.RAM_WADDR, bus.RAM_DATA} !== 30'd0) begin
      errors++; $display("FAIL reset_data got %h want 0", {bus.GREEN, bus.YELLOW, bus.RAM_WADDR, bus.RAM_DATA});
    end
  endtask

  task automatic test_basic();
    int lat;
    clear_ram();
    run_job(pack4(1, 2, 1, 0, 0), pack4(1, 1, 2, 3, 0), 5'd4, 8'd0, lat);
    checks++;
    if (lat !== 39) begin errors++; $display("FAIL basic_latency got %0d want 39", lat); end
    checks++;
    if (bus.GREEN !== 5'd1 || bus.YELLOW !== 5'd2) begin
      errors++; $display("FAIL basic_hints got G%0d Y%0d want G1 Y2", bus.GREEN, bus.YELLOW);
    end
    checks++;
    if (ram[2048] !== 8'd2 || ram[2049] !== 8'd1) begin
      errors++; $display("FAIL basic_ram_hints got %0d/%0d want 2/1", ram[2048], ram[2049]);
    end
    checks++;
    if ({ram[0], ram[1], ram[2], ram[3]} !== {8'd1, 8'd2, 8'd1, 8'd0}) begin
      errors++; $display("FAIL basic_row got %h want 01020100", {ram[0], ram[1], ram[2], ram[3]});
    end
  endtask

  task automatic test_duplicates();
    int lat;
    run_job(pack4(1, 1, 1, 1, 0), pack4(1, 1, 2, 3, 0), 5'd4, 8'd0, lat);
    checks++;
    if (lat !== 39 || bus.GREEN !== 5'd2 || bus.YELLOW !== 5'd0) begin
      errors++; $display("FAIL dup_green got lat%0d G%0d Y%0d want lat39 G2 Y0", lat, bus.GREEN, bus.YELLOW);
    end
    run_job(pack4(3, 2, 1, 1, 0), pack4(1, 1, 2, 3, 0), 5'd4, 8'd0, lat);
    checks++;
    if (lat !== 39 || bus.GREEN !== 5'd0 || bus.YELLOW !== 5'd4) begin
      errors++; $display("FAIL dup_yellow got lat%0d G%0d Y%0d want lat39 G0 Y4", lat, bus.GREEN, bus.YELLOW);
    end
  endtask

  task automatic test_addressing();
    int  lat;
    int  bad;
    logic [7:0] exp_v;
    clear_ram();
    run_job(pack4(1, 2, 1, 0, 1), pack4(1, 1, 2, 3, 0), 5'd4, 8'd3, lat);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      exp_v = (i < 4) ? 8'((i == 1) ? 2 : (i == 3) ? 0 : 1) : 8'(i);
      if (ram[60 + i] !== exp_v) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL addr_row got %0d bad slots want 0", bad); end
    checks++;
    if (ram[2054] !== 8'd2 || ram[2055] !== 8'd1) begin
      errors++; $display("FAIL addr_hints got %0d/%0d want 2/1", ram[2054], ram[2055]);
    end
    checks++;
    if (wr_count !== 22 || hint_wr !== 2 || ram[59] !== 8'hEE || ram[80] !== 8'hEE) begin
      errors++; $display("FAIL addr_count got %0d writes %0d hint want 22 2", wr_count, hint_wr);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cyc = 0;
    int done_cnt = 0;
    kick(pack4(1, 2, 1, 0, 0), pack4(1, 1, 2, 3, 0), 5'd4, 8'd0);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.BUSY) busy_cyc++;
      if (bus.DONE) done_cnt++;
      // Stray requests carrying a different pin count
      bus.PINS_COUNT = 5'd2;
      bus.START = (n == 3 || n == 20 || n == 30);
    end
    bus.START = 1'b0;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
    checks++;
    if (busy_cyc !== 39) begin errors++; $display("FAIL b2b_busy got %0d want 39", busy_cyc); end
    checks++;
    if (bus.GREEN !== 5'd1 || bus.YELLOW !== 5'd2) begin
      errors++; $display("FAIL b2b_hints got G%0d Y%0d want G1 Y2", bus.GREEN, bus.YELLOW);
    end
  endtask

  task automatic test_abort_reset();
    int done_cnt = 0;
    clear_ram();
    // ABORT with START in IDLE: nothing starts
    @(negedge clk); bus.ABORT = 1'b1; bus.START = 1'b1;
    @(negedge clk); bus.ABORT = 1'b0; bus.START = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_start got BUSY %b want 0", bus.BUSY); end
    // ABORT in CROSS
    kick(pack4(1, 1, 1, 1, 0), pack4(1, 1, 2, 3, 0), 5'd4, 8'd0);
    repeat (25) @(negedge clk);
    bus.ABORT = 1'b1;
    @(posedge clk); #1 bus.ABORT = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.RAM_WEN !== 1'b0) begin
      errors++; $display("FAIL abort_idle got BUSY %b WEN %b want 0 0", bus.BUSY, bus.RAM_WEN);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.DONE) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || hint_wr !== 0) begin
      errors++; $display("FAIL abort_quiet got %0d done %0d hint writes want 0 0", done_cnt, hint_wr);
    end
    checks++;
    if (bus.GREEN !== 5'd1 || bus.YELLOW !== 5'd2) begin
      errors++; $display("FAIL abort_hold got G%0d Y%0d want G1 Y2", bus.GREEN, bus.YELLOW);
    end
    // RST while in PIN
    kick(pack4(1, 1, 1, 1, 0), pack4(1, 1, 2, 3, 0), 5'd4, 8'd5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.BUSY, bus.DONE, bus.RAM_WEN, bus.GREEN, bus.YELLOW, bus.RAM_WADDR, bus.RAM_DATA} !== 33'd0) begin
      errors++; $display("FAIL rst_mid got %h want 0",
        {bus.BUSY, bus.DONE, bus.RAM_WEN, bus.GREEN, bus.YELLOW, bus.RAM_WADDR, bus.RAM_DATA});
    end
  endtask

  task automatic test_pin_count_bounds();
    int lat;
    logic [99:0] g;
    logic [99:0] s;
    clear_ram();
    run_job(pack4(1, 2, 1, 0, 0), pack4(1, 2, 1, 0, 0), 5'd0, 8'd1, lat);
    @(negedge clk);
    checks++;
    if (lat !== 23) begin errors++; $display("FAIL p0_latency got %0d want 23", lat); end
    checks++;
    if (ram[2050] !== 8'd0 || ram[2051] !== 8'd0 || wr_count !== 22) begin
      errors++; $display("FAIL p0_ram got %0d/%0d writes %0d want 0/0 22", ram[2050], ram[2051], wr_count);
    end
    // Over-range count clamps to 20; secret is guess rotated by one slot
    for (int i = 0; i < 20; i++) begin
      g[i*5 +: 5] = 5'(i);
      s[i*5 +: 5] = 5'((i + 1) % 20);
    end
    run_job(g, s, 5'd31, 8'd2, lat);
    checks++;
    if (lat !== 423) begin errors++; $display("FAIL p31_latency got %0d want 423", lat); end
    checks++;
    if (bus.GREEN !== 5'd0 || bus.YELLOW !== 5'd20) begin
      errors++; $display("FAIL p31_hints got G%0d Y%0d want G0 Y20", bus.GREEN, bus.YELLOW);
    end
  endtask

  initial begin
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.PINS_COUNT = '0;
    bus.GUESS_INDEX = '0; bus.GUESS = '0; bus.SECRET = '0;
    test_reset();
    test_basic();
    test_duplicates();
    test_addressing();
    test_back_to_back();
    test_abort_reset();
    test_pin_count_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
